// File: rtl/led_seq_pkg.sv
// Shared definitions for the tug-of-war LED sequencer: FSM states, LED mux
// select codes and the per-state output decode used by the sequencer.
package led_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CD_ON     = 3'd1,
        ST_CD_OFF    = 3'd2,
        ST_PLAY      = 3'd3,
        ST_WIN_PAT   = 3'd4,
        ST_WIN_SCORE = 3'd5,
        ST_HOLD      = 3'd6
    } state_e;

    localparam logic [1:0] LED_OFF     = 2'd0;
    localparam logic [1:0] LED_ALL     = 2'd1;
    localparam logic [1:0] LED_SCORE   = 2'd2;
    localparam logic [1:0] LED_PATTERN = 2'd3;

    function automatic logic [1:0] led_for_state(input state_e s);
        logic [1:0] led;
        case (s)
            ST_IDLE:      led = LED_OFF;
            ST_CD_ON:     led = LED_ALL;
            ST_CD_OFF:    led = LED_OFF;
            ST_PLAY:      led = LED_SCORE;
            ST_WIN_PAT:   led = LED_PATTERN;
            ST_WIN_SCORE: led = LED_SCORE;
            ST_HOLD:      led = LED_PATTERN;
            default:      led = LED_OFF;
        endcase
        return led;
    endfunction

    function automatic logic busy_for_state(input state_e s);
        logic b;
        case (s)
            ST_CD_ON, ST_CD_OFF, ST_PLAY, ST_WIN_PAT, ST_WIN_SCORE: b = 1'b1;
            default:                                                b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/led_sequencer_prescaler.sv
// Display-phase prescaler: free-running 0..TICK_DIV-1 counter with a
// synchronous clear so every FSM phase starts from a fresh count.
module tick_prescaler #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] count_r;

    // Phase counter; wraps after the tick cycle or restarts on clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clr || tick) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + CNT_ONE;
        end
    end

    assign tick = (count_r == CNT_LAST);

endmodule

// File: rtl/led_sequencer.sv
// Moore FSM selecting the LED mux source: start countdown flashes, live score
// during play and a blinking win celebration, with a one-cycle go pulse.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV    = 25000000,
    parameter int FLASH_COUNT = 3,
    parameter int WIN_BLINKS  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       game_over,
    output logic [1:0] led_control,
    output logic       go,
    output logic       busy
);

    localparam int FW = $clog2(FLASH_COUNT + 1);
    localparam int BW = $clog2(WIN_BLINKS + 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_COUNT - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(WIN_BLINKS - 1);
    localparam logic [FW-1:0] FLASH_ONE  = FW'(1);
    localparam logic [BW-1:0] BLINK_ONE  = BW'(1);

    state_e        state_r, state_next_s;
    logic [FW-1:0] flash_cnt_r, flash_next_s;
    logic [BW-1:0] blink_cnt_r, blink_next_s;
    logic [1:0]    led_control_r;
    logic          go_r, busy_r;
    logic          tick_s, clr_s, go_next_s;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_s),
        .tick  (tick_s)
    );

    // Next-state and sequence-counter decode; abort overrides everything.
    always_comb begin
        state_next_s = state_r;
        flash_next_s = flash_cnt_r;
        blink_next_s = blink_cnt_r;
        if (abort) begin
            state_next_s = ST_IDLE;
            flash_next_s = '0;
            blink_next_s = '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_HOLD: begin
                    if (start) begin
                        state_next_s = ST_CD_ON;
                        flash_next_s = '0;
                    end else begin
                        state_next_s = state_r;
                    end
                end
                ST_CD_ON: begin
                    if (tick_s) state_next_s = ST_CD_OFF;
                    else        state_next_s = state_r;
                end
                ST_CD_OFF: begin
                    if (!tick_s) begin
                        state_next_s = state_r;
                    end else if (flash_cnt_r == FLASH_LAST) begin
                        state_next_s = ST_PLAY;
                    end else begin
                        state_next_s = ST_CD_ON;
                        flash_next_s = flash_cnt_r + FLASH_ONE;
                    end
                end
                ST_PLAY: begin
                    if (game_over) begin
                        state_next_s = ST_WIN_PAT;
                        blink_next_s = '0;
                    end else begin
                        state_next_s = state_r;
                    end
                end
                ST_WIN_PAT: begin
                    if (tick_s) state_next_s = ST_WIN_SCORE;
                    else        state_next_s = state_r;
                end
                ST_WIN_SCORE: begin
                    if (!tick_s) begin
                        state_next_s = state_r;
                    end else if (blink_cnt_r == BLINK_LAST) begin
                        state_next_s = ST_HOLD;
                    end else begin
                        state_next_s = ST_WIN_PAT;
                        blink_next_s = blink_cnt_r + BLINK_ONE;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                    flash_next_s = '0;
                    blink_next_s = '0;
                end
            endcase
        end
    end

    // Prescaler restarts with each new phase so every phase is TICK_DIV long.
    always_comb begin
        clr_s     = abort || (state_next_s != state_r);
        go_next_s = (state_r == ST_CD_OFF) && (state_next_s == ST_PLAY);
    end

    // State, counters and outputs all register from the next state together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            flash_cnt_r   <= '0;
            blink_cnt_r   <= '0;
            led_control_r <= LED_OFF;
            go_r          <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            flash_cnt_r   <= flash_next_s;
            blink_cnt_r   <= blink_next_s;
            led_control_r <= led_for_state(state_next_s);
            go_r          <= go_next_s;
            busy_r        <= busy_for_state(state_next_s);
        end
    end

    assign led_control = led_control_r;
    assign go          = go_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_led_sequencer.sv
// Randomized scoreboard bench for led_sequencer against a phase/elapsed-time
// reference model of the countdown, play and win sequences.
module tb_led_sequencer;

    localparam int TD = 4;
    localparam int FC = 3;
    localparam int WB = 2;
    localparam int CD_LEN  = 2 * FC * TD;
    localparam int WIN_LEN = 2 * WB * TD;

    localparam int M_IDLE = 0;
    localparam int M_CD   = 1;
    localparam int M_PLAY = 2;
    localparam int M_WIN  = 3;
    localparam int M_HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       game_over;
    logic [1:0] led_control;
    logic       go;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int m_mode   = M_IDLE;
    int m_t      = 0;
    logic [3:0] sb_q[$];

    led_sequencer #(
        .TICK_DIV    (TD),
        .FLASH_COUNT (FC),
        .WIN_BLINKS  (WB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .game_over   (game_over),
        .led_control (led_control),
        .go          (go),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    // Advance the reference model by one sampled clock; returns {led, go, busy}.
    task automatic model_step(input logic s, input logic a, input logic g, output logic [3:0] exp_o);
        logic       gp;
        logic [1:0] led;
        gp = 1'b0;
        if (a) begin
            m_mode = M_IDLE;
            m_t    = 0;
        end else begin
            case (m_mode)
                M_IDLE, M_HOLD: if (s) begin m_mode = M_CD; m_t = 0; end
                M_CD: begin
                    m_t++;
                    if (m_t == CD_LEN) begin m_mode = M_PLAY; m_t = 0; gp = 1'b1; end
                end
                M_PLAY: if (g) begin m_mode = M_WIN; m_t = 0; end
                M_WIN: begin
                    m_t++;
                    if (m_t == WIN_LEN) begin m_mode = M_HOLD; m_t = 0; end
                end
                default: m_mode = M_IDLE;
            endcase
        end
        case (m_mode)
            M_CD:    led = (((m_t / TD) % 2) == 0) ? 2'd1 : 2'd0;
            M_PLAY:  led = 2'd2;
            M_WIN:   led = (((m_t / TD) % 2) == 0) ? 2'd3 : 2'd2;
            M_HOLD:  led = 2'd3;
            default: led = 2'd0;
        endcase
        exp_o = {led, gp, (m_mode == M_CD || m_mode == M_PLAY || m_mode == M_WIN)};
    endtask

    task automatic step(input logic s, input logic a, input logic g);
        logic [3:0] e;
        @(negedge clk);
        #1;
        start     = s;
        abort     = a;
        game_over = g;
        model_step(s, a, g, e);
        sb_q.push_back(e);
    endtask

    task automatic idle_steps(input int n, input logic g);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, g);
    endtask

    task automatic check_reset_now();
        n_checks++;
        if ({led_control, go, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got led=%0d go=%0d busy=%0d, expected led=0 go=0 busy=0",
                     led_control, go, busy);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #1;
        start = 1'b0; abort = 1'b0; game_over = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_now();
        repeat (2) @(negedge clk);
        #1;
        check_reset_now();
        rst_n  = 1'b1;
        m_mode = M_IDLE;
        m_t    = 0;
    endtask

    // Monitor: compare each registered output cycle against the scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (sb_q.size() > 0) begin
            logic [3:0] e;
            e = sb_q.pop_front();
            n_checks++;
            if ({led_control, go, busy} !== e) begin
                n_fail++;
                $display("FAIL outputs at cycle %0d: got led=%0d go=%0d busy=%0d, expected led=%0d go=%0d busy=%0d",
                         cyc, led_control, go, busy, e[3:2], e[1], e[0]);
            end
        end
    end

    initial begin
        rst_n = 1'b1; start = 1'b0; abort = 1'b0; game_over = 1'b0;
        #1 rst_n = 1'b0;
        #2 check_reset_now();
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Idle: game_over ignored, no start.
        idle_steps(3, 1'b1);
        idle_steps(2, 1'b0);

        // Countdown with stray start pulses, then play and win.
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < CD_LEN; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        idle_steps(3, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < WIN_LEN + 3; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));

        // Rematch from HOLD with game_over stuck high.
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < CD_LEN + WIN_LEN + 3; i++) step(1'b0, 1'b0, 1'b1);

        // Abort on the final countdown tick: no go pulse.
        step(1'b1, 1'b0, 1'b0);
        idle_steps(CD_LEN - 1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        idle_steps(3, 1'b0);

        // Abort during WIN_SCORE, and abort with start in IDLE.
        step(1'b1, 1'b0, 1'b0);
        idle_steps(CD_LEN + 2, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        idle_steps(TD + 1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        idle_steps(2, 1'b0);

        // Reset asserted mid-countdown.
        step(1'b1, 1'b0, 1'b0);
        idle_steps(5, 1'b0);
        apply_reset();
        idle_steps(3, 1'b0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 79) == 0),
                 1'($urandom_range(0, 11) == 0));
        end

        repeat (3) @(negedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
